// File: rtl/pop_breeder_if.sv
// ============================================================================
// Module      : pop_breeder_if
// Description : Handshake and data bundle between the GA controller and the
//               repopulation stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface pop_breeder_if #(
    parameter int W      = 30,
    parameter int N_SURV = 10,
    parameter int N_POP  = 20
);
    logic                start;
    logic [W*N_SURV-1:0] sorted;
    logic [W*N_POP-1:0]  pop;
    logic                busy;
    logic                done;

    modport master (output start, output sorted, input pop, input busy, input done);
    modport slave  (input start, input sorted, output pop, output busy, output done);
endinterface

`default_nettype wire

// File: rtl/pop_breeder.sv
// ============================================================================
// Module      : pop_breeder
// Description : Rebuilds a full GA population from the sorted survivor half:
//               elitist copy plus one LFSR-driven crossover child per clock.
//               Optional macro MUTATION_EN adds a rare single-bit mutation.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module pop_breeder #(
    parameter int          W      = 30,
    parameter int          N_SURV = 10,
    parameter int          N_POP  = 20,
    parameter logic [15:0] SEED   = 16'hACE1
) (
    input  wire logic     clk,
    input  wire logic     rst_n,
    pop_breeder_if.slave  bus
);

    localparam int          N_CHILD = N_POP - N_SURV;
    localparam int          KW      = (N_CHILD > 1) ? $clog2(N_CHILD) : 1;
    localparam int          AW      = (N_SURV > 1) ? $clog2(N_SURV) : 1;
    localparam logic [15:0] SEED_EFF = (SEED == 16'h0000) ? 16'h0001 : SEED;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_BREED = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [KW-1:0]       k_q, k_d;
    logic [AW-1:0]       a_q, a_d;
    logic [15:0]         lfsr_q, lfsr_d;
    logic [W*N_POP-1:0]  pop_q, pop_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;

    logic [AW-1:0]       w_b_idx;
    logic [W-1:0]        w_par_a, w_par_b, w_child;
    logic [5:0]          w_cp_raw, w_cp;
`ifdef MUTATION_EN
    logic [5:0]          w_mb_raw, w_mb;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            k_q     <= '0;
            a_q     <= '0;
            lfsr_q  <= SEED_EFF;
            pop_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            k_q     <= k_d;
            a_q     <= a_d;
            lfsr_q  <= lfsr_d;
            pop_q   <= pop_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    // Parents come from the latched survivor copy held in the low half of pop.
    always_comb begin
        w_b_idx  = (a_q == AW'(N_SURV - 1)) ? '0 : a_q + AW'(1);
        w_par_a  = pop_q[W*int'(a_q) +: W];
        w_par_b  = pop_q[W*int'(w_b_idx) +: W];
        w_cp_raw = {1'b0, lfsr_q[4:0]};
        w_cp     = (w_cp_raw >= 6'(W)) ? w_cp_raw - 6'(W) : w_cp_raw;
        w_child  = '0;
        for (int j = 0; j < W; j++) begin
            w_child[j] = (j < int'(w_cp)) ? w_par_a[j] : w_par_b[j];
        end
`ifdef MUTATION_EN
        w_mb_raw = {1'b0, lfsr_q[9:5]};
        w_mb     = (w_mb_raw >= 6'(W)) ? w_mb_raw - 6'(W) : w_mb_raw;
        if (lfsr_q[15:13] == 3'b000) begin
            w_child[int'(w_mb)] = ~w_child[int'(w_mb)];
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        k_d     = k_q;
        a_d     = a_q;
        lfsr_d  = lfsr_q;
        pop_d   = pop_q;
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    pop_d[W*N_SURV-1:0] = bus.sorted;
                    k_d                 = '0;
                    a_d                 = '0;
                    state_d             = S_BREED;
                end
            end
            S_BREED: begin
                pop_d[W*(N_SURV + int'(k_q)) +: W] = w_child;
                lfsr_d = {lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5], lfsr_q[15:1]};
                a_d    = w_b_idx;
                if (k_q == KW'(N_CHILD - 1)) begin
                    state_d = S_DONE;
                end else begin
                    k_d = k_q + KW'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d == S_BREED);
        done_d = (state_q == S_DONE);
    end

    assign bus.pop  = pop_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;

endmodule

`default_nettype wire

// File: doc/pop_breeder.md
Name: pop_breeder

Overview:
- Repopulation stage of the GA loop; the inverse of the population sorter.
- Takes the sorted survivor half (fittest first) and rebuilds a full population: survivors copied unchanged (elitism), plus children made by single-point crossover of adjacent survivors.
- Crossover points come from an internal LFSR.
- The rebuilt population feeds the fitness/sort stage for the next generation.

Parameters:
- W, 30, bits per individual; legal range 17..32.
- N_SURV, 10, survivors in; sorted width = W*N_SURV.
- N_POP, 20, individuals out; pop width = W*N_POP; N_POP > N_SURV.
- SEED, 16'hACE1, LFSR reset value; a value of 0 is forced to 16'h0001.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request; sampled only in IDLE.
- sorted  in  W*N_SURV  survivors; individual i at [W*i +: W]; i=0 fittest.
- pop  out  W*N_POP  rebuilt population, same packing.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  one-cycle completion pulse.

Behaviour:
- Reset (async, rst_n=0):
  - pop=0, busy=0, done=0.
  - state=IDLE, child counter=0, LFSR=SEED.
  - Reset mid-run aborts immediately; no partial result is preserved.
- Definitions: N_CHILD = N_POP-N_SURV. The LFSR is 16-bit Fibonacci, polynomial x^16+x^14+x^13+x^11+1.
- IDLE:
  - On start=1: latch sorted into pop[0 .. W*N_SURV-1]; clear child counter k=0; go to BREED; busy=1 from the next cycle.
  - start=0: hold; pop keeps its last value.
- BREED, one child per clock, for k = 0..N_CHILD-1:
  - A = survivor (k mod N_SURV); B = survivor ((k+1) mod N_SURV); read from the latched copy, not the live sorted input.
  - cp = L[4:0], minus W if >= W. L is the current LFSR value.
  - child bit j = A[j] if j < cp, else B[j]. cp=0 gives a pure copy of B.
  - Write the child to pop individual N_SURV+k. The LFSR advances on the same edge, so child 0 uses SEED.
  - After child N_CHILD-1 is written, go to DONE.
- DONE (one cycle): done=1, busy=0; return to IDLE.
- Latency: done is high during the cycle after the (N_CHILD+1)th rising edge following the edge that sampled start. Defaults: edge 11.
- start while busy or in DONE is ignored; no queuing.
- start in the same cycle as the DONE→IDLE transition is not accepted; it must be presented in IDLE.
- The LFSR is not re-seeded per run; successive runs continue the sequence.
- pop is stable from done until the next accepted start. Partially written children are visible while busy.

Optional Feature:
- Macro: MUTATION_EN.
- Defined: after crossover, each child may have one bit inverted.
  - Condition: L[15:13]==3'b000 (probability 1/8).
  - Bit index: L[9:5], minus W if >= W.
  - Same LFSR sample as the crossover; no extra cycles; survivors are never mutated.
- Undefined: no mutation logic; children are pure crossover.

Test Plan:
1. Reset: rst_n=0 with random sorted -> pop=0, busy=0, done=0; LFSR state = 16'hACE1 (check via child 0 of the first run).
2. All survivors 0, MUTATION_EN off, start pulse -> busy for 10 cycles, done on edge 11 for exactly 1 cycle, pop = 600'b0.
3. Even survivors 30'h0, odd survivors 30'h3FFFFFFF, MUTATION_EN off -> child 0 (pop[329:300]) = 30'h3FFFFFFE (cp=1 from seed); pop[299:0] equals the input; each remaining child matches the reference model.
4. start re-pulsed on cycles 3 and 7 while busy -> ignored; done still on edge 11 only; a start in IDLE afterwards begins a run that continues the LFSR sequence, not from the seed.
5. rst_n dropped on cycle 5 of BREED -> pop=0, busy=0 immediately, no done; release and start -> normal completion at edge 11.
6. MUTATION_EN defined, all survivors 0 -> pop[299:0]=0; each child has popcount <= 1, with set bits exactly where the model predicts from the L[15:13] and L[9:5] sequence.
